state_stream_tx: RTL and testbench
==================================

Name: state_stream_tx

Overview:
- Downstream end of the state-prediction stage. Captures the 12-element predicted state vector X_{k+1,k} when the prediction stage signals completion.
- Streams the vector out one 64-bit element per transfer over a valid/ready interface. This feeds the covariance/measurement stages and the host readback FIFO.
- Holds one pending vector so a back-to-back prediction is not lost while a previous one is still draining.

Parameters:
- DWIDTH, 64, element width in bits
- N, 12, elements per state vector
- IDXW, 4, width of element index (>= clog2(N))
- FRW, 8, width of frame counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- X_k1k  in  DWIDTH x [N-1:0]  predicted state vector, valid while SCU_Done high
- SCU_Done  in  1  prediction-complete flag from the state-update stage (level, may stay high several cycles)
- out_data  out  DWIDTH  current element
- out_idx  out  IDXW  element index 0..N-1
- out_frame  out  FRW  frame number of the current vector
- out_last  out  1  high with out_idx == N-1
- out_valid  out  1  element available
- out_ready  in  1  consumer accepts
- busy  out  1  active or pending slot occupied
- ovf_err  out  1  sticky: a vector was dropped
- clr_err  in  1  synchronous clear of ovf_err

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n); the block is initialised on assertion.
- Reset values:
  - out_valid = 0, out_data = 0, out_idx = 0, out_frame = 0, out_last = 0, busy = 0, ovf_err = 0.
  - Both slots empty, FSM in IDLE, SCU_Done edge register cleared to 0.
- Capture event (cap):
  - cap = SCU_Done & ~SCU_Done_q, i.e. a rising edge.
  - The whole X_k1k vector is registered in the cap cycle.
  - A level held high produces exactly one capture.
- Storage: two slots, ACTIVE (being streamed) and PENDING, each N x DWIDTH plus a valid bit.
- FSM states: IDLE, SEND.
- IDLE:
  - On cap, load ACTIVE, set idx = 0, go to SEND.
  - out_valid rises the cycle after cap, giving a 1-cycle capture-to-first-valid latency.
- SEND:
  - out_valid = 1, out_data = ACTIVE[idx], out_last = (idx == N-1).
  - A transfer occurs when out_valid & out_ready; on a transfer, idx increments.
  - out_data, out_idx, out_last and out_frame hold stable while out_valid & ~out_ready.
- End of vector (transfer with idx == N-1):
  - out_frame increments, wrapping 2^FRW-1 -> 0.
  - If PENDING is valid: move PENDING to ACTIVE, set idx = 0, stay in SEND. No bubble: out_valid stays 1 and the next cycle shows element 0 of the new vector.
  - Else if cap occurs in the same cycle: load the new vector directly into ACTIVE, set idx = 0, stay in SEND, no bubble.
  - Else go to IDLE; out_valid = 0 next cycle.
- cap while in SEND, not at end of vector:
  - PENDING empty: load PENDING.
  - PENDING full: drop the new vector and set ovf_err. PENDING keeps the older vector.
- cap at end of vector with PENDING full: PENDING moves to ACTIVE and the new vector loads into PENDING. No drop.
- ovf_err:
  - Sticky; cleared by clr_err.
  - If clr_err and a drop occur in the same cycle, set wins.
- busy = ACTIVE valid | PENDING valid.
- out_ready is ignored while out_valid = 0. No combinational path from out_ready to out_valid.
- Reset mid-stream: all state is discarded immediately. After reset release, nothing is emitted until a fresh SCU_Done rising edge; a SCU_Done already high at reset release counts as an edge.

Test Plan:
- Single vector: X_k1k[i] = 64'h1000+i, SCU_Done high 1 cycle, out_ready = 1 -> out_valid rises 1 cycle later; 12 consecutive transfers with idx 0..11 and data 64'h1000..64'h100B; out_last only on idx 11; out_frame 0 during the vector, 1 afterwards; busy drops after the last transfer.
- Backpressure: out_ready toggles 1,0,0,1... -> each element held stable while stalled; exactly 12 transfers; no duplicated or skipped index.
- Back-to-back vectors: second SCU_Done edge 3 cycles after the first (A = 64'hA0+i, B = 64'hB0+i), out_ready = 1 -> 24 transfers with no bubble between A[11] and B[0]; out_frame goes 0 -> 1 -> 2; ovf_err = 0.
- Overflow: three edges during the first vector while out_ready = 0 -> vectors 1 and 2 are streamed, vector 3 is dropped, ovf_err = 1; clr_err pulse -> ovf_err = 0.
- Edge/level: SCU_Done held high for 20 cycles -> exactly one vector streamed. Edge coincident with the last-element transfer and PENDING full -> no drop, three vectors streamed in order.
- Reset mid-stream: rst_n low at idx 5 -> outputs go to reset values asynchronously; after release, no output until a new edge; the next vector starts at idx 0 with frame 0.

Source files
------------

// File: rtl/state_stream_tx_if.sv
// Element stream from state_stream_tx to its consumer.
// Handshake: an element transfers on a clock edge where out_valid & out_ready are both high; while out_valid is high and out_ready is low, every out_* field holds steady.
interface state_stream_tx_if #(
  parameter int DWIDTH = 64,
  parameter int IDXW   = 4,
  parameter int FRW    = 8
);
  logic [DWIDTH-1:0] out_data;
  logic [IDXW-1:0]   out_idx;
  logic [FRW-1:0]    out_frame;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data, out_idx, out_frame, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_idx, out_frame, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/state_stream_tx.sv
// Captures the predicted state vector on each rising SCU_Done and streams it one element per transfer.
// Two slots are kept: ACTIVE, which is being streamed, and one PENDING vector waiting behind it.
module state_stream_tx #(
  parameter int DWIDTH = 64,
  parameter int N      = 12,
  parameter int IDXW   = 4,
  parameter int FRW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0][DWIDTH-1:0]   X_k1k,
  input  logic                       SCU_Done,
  state_stream_tx_if.master          strm,
  output logic                       busy,
  output logic                       ovf_err,
  input  logic                       clr_err,
  output logic                       dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [N-1:0][DWIDTH-1:0]   act_q, act_d;
  logic [N-1:0][DWIDTH-1:0]   pend_q, pend_d;
  logic                       pend_vld_q, pend_vld_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [FRW-1:0]             frame_q, frame_d;
  logic                       scu_q;
  logic                       ovf_q, ovf_d;

  logic cap, xfer, last_el, drop;

  assign cap     = SCU_Done & ~scu_q;
  assign xfer    = (state_q == SEND) & strm.out_ready;
  assign last_el = (idx_q == IDXW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      idx_q      <= '0;
      frame_q    <= '0;
      scu_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      scu_q      <= SCU_Done;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    drop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap) begin
          act_d   = X_k1k;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) idx_d = idx_q + IDXW'(1);
        if (xfer && last_el) begin
          frame_d = frame_q + FRW'(1);
          idx_d   = '0;
          // End of vector frees ACTIVE, so a coincident capture never drops.
          if (pend_vld_q) begin
            act_d = pend_q;
            if (cap) pend_d = X_k1k;
            else     pend_vld_d = 1'b0;
          end else if (cap) begin
            act_d = X_k1k;
          end else begin
            state_d = IDLE;
          end
        end else if (cap) begin
          if (!pend_vld_q) begin
            pend_d     = X_k1k;
            pend_vld_d = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = drop ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
  end

  assign strm.out_valid = (state_q == SEND);
  assign strm.out_data  = act_q[idx_q];
  assign strm.out_idx   = idx_q;
  assign strm.out_frame = frame_q;
  assign strm.out_last  = (state_q == SEND) & last_el;
  assign busy           = (state_q == SEND) | pend_vld_q;
  assign ovf_err        = ovf_q;
  assign dbg_state_o    = (state_q == SEND);

endmodule

// File: tb/tb_state_stream_tx.sv
// Bench for state_stream_tx: cycle table for a single vector, directed corner sequences and random traffic,
// all compared every cycle against a queue-based model of the two-slot stream.
module tb_state_stream_tx;
  localparam int N = 12;
  typedef logic [N-1:0][63:0] vec_t;

  typedef struct {
    logic        done;
    logic        ready;
    logic        exp_valid;
    logic [3:0]  exp_idx;
    logic [63:0] exp_data;
    logic        exp_last;
    logic [7:0]  exp_frame;
    logic        exp_busy;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0;
  logic ready = 1'b0;
  logic clr = 1'b0;
  vec_t x_in = '0;
  logic busy, ovf_err, dbg_state;

  int checks = 0;
  int fails = 0;
  int xfer_cnt = 0;

  vec_t       mq[$];
  int         m_idx = 0;
  logic [7:0] m_frame = '0;
  logic       m_ovf = 1'b0;
  logic       m_prev = 1'b0;

  state_stream_tx_if #(.DWIDTH(64), .IDXW(4), .FRW(8)) strm_if ();
  assign strm_if.out_ready = ready;

  state_stream_tx #(.DWIDTH(64), .N(N), .IDXW(4), .FRW(8)) dut (
    .clk(clk), .rst_n(rst_n), .X_k1k(x_in), .SCU_Done(done), .strm(strm_if),
    .busy(busy), .ovf_err(ovf_err), .clr_err(clr), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the stream is a queue of at most two whole vectors; its head is the one being sent.
  always @(negedge rst_n) begin
    mq.delete();
    m_idx = 0; m_frame = '0; m_ovf = 1'b0; m_prev = 1'b0;
  end

  always @(posedge clk) begin
    logic cap, drp;
    if (rst_n) begin
      cap = done && !m_prev;
      m_prev = done;
      drp = 1'b0;
      if (mq.size() > 0 && ready) begin
        m_idx++;
        if (m_idx == N) begin
          void'(mq.pop_front());
          m_idx = 0;
          m_frame = m_frame + 8'd1;
        end
      end
      if (cap) begin
        if (mq.size() < 2) mq.push_back(x_in);
        else drp = 1'b1;
      end
      if (drp) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic ev;
    ev = (mq.size() != 0);
    chk("valid", {63'd0, strm_if.out_valid}, {63'd0, ev});
    chk("busy", {63'd0, busy}, {63'd0, ev});
    chk("ovf_err", {63'd0, ovf_err}, {63'd0, m_ovf});
    chk("frame", {56'd0, strm_if.out_frame}, {56'd0, m_frame});
    chk("last", {63'd0, strm_if.out_last}, {63'd0, ev && (m_idx == N - 1)});
    chk("dbg_state", {63'd0, dbg_state}, {63'd0, ev});
    if (ev) begin
      chk("idx", {60'd0, strm_if.out_idx}, 64'(m_idx));
      chk("data", strm_if.out_data, mq[0][m_idx]);
    end
    if (strm_if.out_valid && ready) xfer_cnt++;
  end

  task automatic cyc(input logic d, input logic r, input logic c);
    @(posedge clk);
    #1;
    done = d; ready = r; clr = c;
  endtask

  function automatic vec_t mk(input logic [63:0] base);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = base + 64'(i);
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = {$urandom, $urandom};
    return v;
  endfunction

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
  endtask

  row_t tbl[14];
  logic [7:0] f0;

  initial begin
    // Single vector, cycle by cycle: row r drives inputs after an edge and names the outputs that edge produced.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0};
    for (int r = 1; r <= 12; r++)
      tbl[r] = '{1'b0, 1'b1, 1'b1, 4'(r - 1), 64'h1000 + 64'(r - 1), (r == 12), 8'd0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 8'd1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {63'd0, strm_if.out_valid}, 64'd0);
    chk("reset_data", strm_if.out_data, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    drain(3);

    x_in = mk(64'h1000);
    xfer_cnt = 0;
    for (int r = 0; r < 14; r++) begin
      cyc(tbl[r].done, tbl[r].ready, 1'b0);
      @(negedge clk);
      chk("tbl_valid", {63'd0, strm_if.out_valid}, {63'd0, tbl[r].exp_valid});
      chk("tbl_frame", {56'd0, strm_if.out_frame}, {56'd0, tbl[r].exp_frame});
      chk("tbl_busy", {63'd0, busy}, {63'd0, tbl[r].exp_busy});
      chk("tbl_last", {63'd0, strm_if.out_last}, {63'd0, tbl[r].exp_last});
      if (tbl[r].exp_valid) begin
        chk("tbl_idx", {60'd0, strm_if.out_idx}, {60'd0, tbl[r].exp_idx});
        chk("tbl_data", strm_if.out_data, tbl[r].exp_data);
      end
    end
    chk("single_xfers", 64'(xfer_cnt), 64'd12);

    // Backpressure 1,0,0 pattern
    x_in = rnd_vec();
    xfer_cnt = 0;
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) cyc(1'b0, (i % 3) == 0, 1'b0);
    drain(3);
    chk("bp_xfers", 64'(xfer_cnt), 64'd12);
    chk("bp_idle", {63'd0, busy}, 64'd0);

    // Back-to-back: second edge three cycles after the first
    f0 = strm_if.out_frame;
    xfer_cnt = 0;
    x_in = mk(64'hA0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    x_in = mk(64'hB0);
    cyc(1'b1, 1'b1, 1'b0);
    drain(30);
    chk("b2b_xfers", 64'(xfer_cnt), 64'd24);
    chk("b2b_frame", {56'd0, strm_if.out_frame}, {56'd0, f0 + 8'd2});
    chk("b2b_ovf", {63'd0, ovf_err}, 64'd0);

    // Overflow: three edges while stalled, the third is dropped
    xfer_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      x_in = mk(64'h100 * 64'(k + 1));
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    drain(30);
    chk("ovf_xfers", 64'(xfer_cnt), 64'd24);
    chk("ovf_set", {63'd0, ovf_err}, 64'd1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("ovf_clr", {63'd0, ovf_err}, 64'd0);

    // Level held for 20 cycles gives one capture
    xfer_cnt = 0;
    x_in = rnd_vec();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0);
    drain(15);
    chk("level_xfers", 64'(xfer_cnt), 64'd12);

    // Third edge lands on the idx 11 transfer with PENDING full
    xfer_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 0) x_in = mk(64'h1_0000);
      if (c == 2) x_in = mk(64'h2_0000);
      if (c == 12) x_in = mk(64'h3_0000);
      cyc((c == 0) || (c == 2) || (c == 12), 1'b1, 1'b0);
    end
    drain(30);
    chk("coinc_xfers", 64'(xfer_cnt), 64'd36);
    chk("coinc_ovf", {63'd0, ovf_err}, 64'd0);

    // Reset while idx 5 is on the bus
    x_in = rnd_vec();
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("pre_rst_idx", {60'd0, strm_if.out_idx}, 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'd0, strm_if.out_valid}, 64'd0);
    chk("rst_data", strm_if.out_data, 64'd0);
    chk("rst_idx", {60'd0, strm_if.out_idx}, 64'd0);
    chk("rst_frame", {56'd0, strm_if.out_frame}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    drain(5);
    chk("post_rst_quiet", {63'd0, strm_if.out_valid}, 64'd0);
    xfer_cnt = 0;
    x_in = mk(64'h5000);
    cyc(1'b1, 1'b1, 1'b0);
    drain(15);
    chk("post_rst_xfers", 64'(xfer_cnt), 64'd12);
    chk("post_rst_frame", {56'd0, strm_if.out_frame}, 64'd1);

    // SCU_Done already high when reset releases
    cyc(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    xfer_cnt = 0;
    x_in = mk(64'h6000);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0);
    drain(12);
    chk("lvl_rst_xfers", 64'(xfer_cnt), 64'd12);

    // Random traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      int thr;
      logic d;
      thr = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 2 : 3);
      d = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 5) == 0) d = !d;
        x_in = rnd_vec();
        cyc(d, $urandom_range(0, 3) >= thr, $urandom_range(0, 15) == 0);
      end
    end
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
